matching_memory: RTL
====================

# matching_memory

Operand-matching stage directly downstream of the dispatcher. It consumes two-operand worker-result tokens (dest option LEFT or RIGHT) and parks each one in an associative table keyed by (dest_addr, color). When the partner operand arrives, it emits a packet request carrying both operands toward packet_loader. It is the synchronisation point of the dataflow machine: nothing fires until both inputs of a node instance are present.

## Interface

- Clock is `CLK`; reset is `RST`, synchronous, active-high.
- Parameters
  - `DEST_ADDR_WIDTH`, 16: node address field.
  - `COLOR_WIDTH`, 16: context/color tag field.
  - `DATA_WIDTH`, 32: operand field.
  - `DEPTH`, 16: table entries; power of two, ≥ 2.
  - `IDX_WIDTH`, log2(DEPTH): table index.
  - `WORKER_RESULT_WIDTH`, 3+DEST_ADDR_WIDTH+COLOR_WIDTH+DATA_WIDTH: layout MSB→LSB is {dest_option, dest_addr, color, data}.
  - `PACKET_REQUEST_WIDTH`, 3+DEST_ADDR_WIDTH+COLOR_WIDTH+2·DATA_WIDTH: layout MSB→LSB is {dest_option, dest_addr, color, data1, data2}.
- Ports
  - `CLK`, in, 1: clock.
  - `RST`, in, 1: synchronous active-high reset.
  - `RECEIVE_WR_VALID`, in, 1: token offered by the dispatcher.
  - `RECEIVE_WR_DATA`, in, WORKER_RESULT_WIDTH: token.
  - `RECEIVE_WR_READY`, out, 1: registered accept.
  - `SEND_PR_VALID`, out, 1: matched request valid.
  - `SEND_PR_DATA`, out, PACKET_REQUEST_WIDTH: matched request.
  - `SEND_PR_READY`, in, 1: packet_loader accept.
  - `OVERFLOW`, out, 1: sticky; a token was dropped because the table was full.
  - `OCCUPANCY`, out, IDX_WIDTH+1: count of valid entries.

## Operation

- Entry fields: valid, side (0 = LEFT, 1 = RIGHT), dest_addr, color, data. Reset clears every valid bit, `OCCUPANCY` and `OVERFLOW`.
- FSM states: S_RECEIVE, S_PROBE, S_PR_SEND.
  - S_RECEIVE: `RECEIVE_WR_READY` is 1. On VALID&&READY, latch the token. Dest option LEFT/RIGHT → S_PROBE. Any other option → discard the token and stay in S_RECEIVE.
  - S_PROBE: hash h = (dest_addr ^ color)[IDX_WIDTH-1:0]. Probe i (i = 0..DEPTH-1) examines slot (h+i) mod DEPTH, one slot per cycle, wrapping around the table. The first empty slot seen is remembered.
    - Match: slot valid, tag equal, side opposite to the token. Clear the slot, decrement `OCCUPANCY`, build the request, go to S_PR_SEND.
    - A same-side entry with an equal tag is not a match; probing continues.
    - After DEPTH probes with no match:
      - If an empty slot was seen, write the token there, increment `OCCUPANCY`, go to S_RECEIVE.
      - Otherwise set `OVERFLOW`, drop the token, go to S_RECEIVE.
  - S_PR_SEND: hold `SEND_PR_VALID` with stable data until VALID&&READY, then go to S_RECEIVE.
- Request fields: dest_option = DEST_OPTION_EXEC; dest_addr and color from the token; data1 = LEFT operand and data2 = RIGHT operand, regardless of arrival order.
- Only one token is in flight at a time; no new input is accepted during S_PROBE or S_PR_SEND.

## Timing

- Reset values: `RECEIVE_WR_READY`=0 (rises the cycle after `RST` deasserts), `SEND_PR_VALID`=0, `SEND_PR_DATA`=0, `OVERFLOW`=0, `OCCUPANCY`=0.
- Accept at cycle T: `RECEIVE_WR_READY` is 0 at T+1; probe i happens in cycle T+1+i.
- Match at probe i: `SEND_PR_VALID`=1 from cycle T+2+i. If `SEND_PR_READY` is already high, the handshake completes that cycle, VALID drops at T+3+i and READY rises at T+3+i.
- Store or overflow: decided in cycle T+DEPTH; `RECEIVE_WR_READY`=1 at T+DEPTH+1. `OCCUPANCY` and `OVERFLOW` update in the same cycle the table is written.
- Match with the slot at h: probe 0, so VALID is high at T+2.
- Full table with a matching entry: the match wins and no overflow is flagged.
- `OCCUPANCY` saturates logically at DEPTH; it never wraps because stores are refused when the table is full.
- `RST` mid-probe or mid-send: the in-flight token is lost, the table is cleared, `SEND_PR_VALID` is 0 on the next cycle.

## Structure

- Shared include (param.vh): field widths, DEST_OPTION_* encodings, `DEPTH`.
- Shared include (construct.vh): `make_packet_request`.
- Shared include (extract_wr_data.vh): field extractors, reused here.
- Handshake registers use the existing `sendAlways` / `receiveAlways` macros.
- One natural sub-module: `matching_table`, the register-array entry storage with one combinational read port and one write/clear port. The FSM, probe counter and first-empty tracker stay in the top.

## Test plan

- LEFT(addr=5, color=1, data=0xA) then RIGHT(5, 1, 0xB) → one request {EXEC, 5, 1, 0xA, 0xB}; `OCCUPANCY` goes 1→0.
- RIGHT(5, 1, 0xB) first, then LEFT(5, 1, 0xA) → same request, data1=0xA, data2=0xB.
- LEFT(5, 1) then LEFT(5, 2) then RIGHT(5, 2, 0x7) → one request color=2; `OCCUPANCY` ends at 1.
- DEPTH tokens with the same hash, all LEFT with distinct tags → all stored with wrap-around; one more unmatched LEFT → `OVERFLOW`=1, `OCCUPANCY`=DEPTH. Then the RIGHT partner of the first token → request emitted, no overflow change.
- Hold `SEND_PR_READY`=0 for 5 cycles after a match → VALID and DATA stable for 5 cycles; READY low throughout.
- Assert `RST` during S_PROBE and during S_PR_SEND → all outputs at reset values next cycle; a subsequent lone RIGHT is stored, not matched.

Source files
------------

// File: rtl/matching_memory_pkg.sv
// Shared definitions for the operand-matching stage: destination option
// encodings, operand side encoding and the controller state type.
package matching_memory_pkg;

    localparam logic [2:0] DEST_OPTION_EXEC  = 3'd1;
    localparam logic [2:0] DEST_OPTION_LEFT  = 3'd2;
    localparam logic [2:0] DEST_OPTION_RIGHT = 3'd3;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        S_RECEIVE = 2'd0,
        S_PROBE   = 2'd1,
        S_PR_SEND = 2'd2
    } mm_state_e;

    function automatic logic is_operand_option(input logic [2:0] opt);
        return (opt == DEST_OPTION_LEFT) || (opt == DEST_OPTION_RIGHT);
    endfunction

endpackage

// File: rtl/matching_memory_table.sv
// Matching table: register-array entry storage with one combinational read
// port and one write/clear port (wr_valid=0 clears the addressed slot).
module matching_memory_table #(
    parameter int DEST_ADDR_WIDTH = 16,
    parameter int COLOR_WIDTH     = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 16,
    parameter int IDX_WIDTH       = $clog2(DEPTH)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [IDX_WIDTH-1:0]       rd_idx,
    output logic                       rd_valid,
    output logic                       rd_side,
    output logic [DEST_ADDR_WIDTH-1:0] rd_addr,
    output logic [COLOR_WIDTH-1:0]     rd_color,
    output logic [DATA_WIDTH-1:0]      rd_data,
    input  logic                       wr_en,
    input  logic [IDX_WIDTH-1:0]       wr_idx,
    input  logic                       wr_valid,
    input  logic                       wr_side,
    input  logic [DEST_ADDR_WIDTH-1:0] wr_addr,
    input  logic [COLOR_WIDTH-1:0]     wr_color,
    input  logic [DATA_WIDTH-1:0]      wr_data
);

    logic [DEPTH-1:0]           valid_r;
    logic                       side_r  [DEPTH];
    logic [DEST_ADDR_WIDTH-1:0] addr_r  [DEPTH];
    logic [COLOR_WIDTH-1:0]     color_r [DEPTH];
    logic [DATA_WIDTH-1:0]      data_r  [DEPTH];

    // Valid bits: the only state reset has to clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx] <= wr_valid;
        end
    end

    // Payload is only meaningful while its valid bit is set
    always_ff @(posedge CLK) begin
        if (wr_en && wr_valid) begin
            side_r[wr_idx]  <= wr_side;
            addr_r[wr_idx]  <= wr_addr;
            color_r[wr_idx] <= wr_color;
            data_r[wr_idx]  <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_side  = side_r[rd_idx];
    assign rd_addr  = addr_r[rd_idx];
    assign rd_color = color_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/matching_memory.sv
// Operand-matching stage: parks two-operand tokens in a hashed, linearly
// probed table and emits a packet request once both operands are present.
module matching_memory
    import matching_memory_pkg::*;
#(
    parameter int DEST_ADDR_WIDTH      = 16,
    parameter int COLOR_WIDTH          = 16,
    parameter int DATA_WIDTH           = 32,
    parameter int DEPTH                = 16,
    parameter int IDX_WIDTH            = $clog2(DEPTH),
    parameter int WORKER_RESULT_WIDTH  = 3 + DEST_ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH,
    parameter int PACKET_REQUEST_WIDTH = 3 + DEST_ADDR_WIDTH + COLOR_WIDTH + 2 * DATA_WIDTH
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            RECEIVE_WR_VALID,
    input  logic [WORKER_RESULT_WIDTH-1:0]  RECEIVE_WR_DATA,
    output logic                            RECEIVE_WR_READY,
    output logic                            SEND_PR_VALID,
    output logic [PACKET_REQUEST_WIDTH-1:0] SEND_PR_DATA,
    input  logic                            SEND_PR_READY,
    output logic                            OVERFLOW,
    output logic [IDX_WIDTH:0]              OCCUPANCY
);

    localparam logic [IDX_WIDTH-1:0] IDX_ONE    = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_WIDTH-1:0] LAST_PROBE = {IDX_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH:0]   OCC_ONE    = {{IDX_WIDTH{1'b0}}, 1'b1};

    mm_state_e state_r, state_next;

    logic [2:0]                      wr_option_s;
    logic [DEST_ADDR_WIDTH-1:0]      wr_addr_s;
    logic [COLOR_WIDTH-1:0]          wr_color_s;
    logic [DATA_WIDTH-1:0]           wr_data_s;

    logic                            tok_side_r;
    logic [DEST_ADDR_WIDTH-1:0]      tok_addr_r;
    logic [COLOR_WIDTH-1:0]          tok_color_r;
    logic [DATA_WIDTH-1:0]           tok_data_r;
    logic [IDX_WIDTH-1:0]            hash_r;
    logic [IDX_WIDTH-1:0]            probe_r;
    logic                            found_r;
    logic [IDX_WIDTH-1:0]            empty_idx_r;

    logic                            ready_r;
    logic                            pr_valid_r;
    logic [PACKET_REQUEST_WIDTH-1:0] pr_data_r;
    logic [IDX_WIDTH:0]              occ_r;
    logic                            ovf_r;

    logic [IDX_WIDTH-1:0]            slot_s;
    logic                            rd_valid_s;
    logic                            rd_side_s;
    logic [DEST_ADDR_WIDTH-1:0]      rd_addr_s;
    logic [COLOR_WIDTH-1:0]          rd_color_s;
    logic [DATA_WIDTH-1:0]           rd_data_s;
    logic                            accept_s;
    logic                            pr_done_s;
    logic                            tag_hit_s;
    logic                            last_probe_s;
    logic                            match_s;
    logic                            store_s;
    logic                            drop_s;
    logic                            tbl_wr_en_s;
    logic                            tbl_wr_valid_s;
    logic [IDX_WIDTH-1:0]            tbl_wr_idx_s;
    logic [DATA_WIDTH-1:0]           left_data_s;
    logic [DATA_WIDTH-1:0]           right_data_s;
    logic [PACKET_REQUEST_WIDTH-1:0] request_s;

    assign wr_option_s = RECEIVE_WR_DATA[WORKER_RESULT_WIDTH-1 -: 3];
    assign wr_addr_s   = RECEIVE_WR_DATA[DATA_WIDTH + COLOR_WIDTH +: DEST_ADDR_WIDTH];
    assign wr_color_s  = RECEIVE_WR_DATA[DATA_WIDTH +: COLOR_WIDTH];
    assign wr_data_s   = RECEIVE_WR_DATA[0 +: DATA_WIDTH];

    assign accept_s     = RECEIVE_WR_VALID && ready_r;
    assign pr_done_s    = pr_valid_r && SEND_PR_READY;
    assign slot_s       = hash_r + probe_r;
    assign last_probe_s = (probe_r == LAST_PROBE);
    assign tag_hit_s    = rd_valid_s && (rd_addr_s == tok_addr_r) &&
                          (rd_color_s == tok_color_r) && (rd_side_s != tok_side_r);

    // Operands are ordered by side, not by arrival
    assign left_data_s  = (tok_side_r == SIDE_LEFT) ? tok_data_r : rd_data_s;
    assign right_data_s = (tok_side_r == SIDE_LEFT) ? rd_data_s : tok_data_r;
    assign request_s    = {DEST_OPTION_EXEC, tok_addr_r, tok_color_r, left_data_s, right_data_s};

    matching_memory_table #(
        .DEST_ADDR_WIDTH (DEST_ADDR_WIDTH),
        .COLOR_WIDTH     (COLOR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .DEPTH           (DEPTH),
        .IDX_WIDTH       (IDX_WIDTH)
    ) u_table (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (slot_s),
        .rd_valid (rd_valid_s),
        .rd_side  (rd_side_s),
        .rd_addr  (rd_addr_s),
        .rd_color (rd_color_s),
        .rd_data  (rd_data_s),
        .wr_en    (tbl_wr_en_s),
        .wr_idx   (tbl_wr_idx_s),
        .wr_valid (tbl_wr_valid_s),
        .wr_side  (tok_side_r),
        .wr_addr  (tok_addr_r),
        .wr_color (tok_color_r),
        .wr_data  (tok_data_r)
    );

    // Controller state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_RECEIVE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next state and per-probe table decisions; a match beats store/overflow
    always_comb begin
        state_next     = state_r;
        match_s        = 1'b0;
        store_s        = 1'b0;
        drop_s         = 1'b0;
        tbl_wr_en_s    = 1'b0;
        tbl_wr_valid_s = 1'b0;
        tbl_wr_idx_s   = slot_s;
        case (state_r)
            S_RECEIVE: begin
                if (accept_s && is_operand_option(wr_option_s)) begin
                    state_next = S_PROBE;
                end else begin
                    state_next = S_RECEIVE;
                end
            end
            S_PROBE: begin
                if (tag_hit_s) begin
                    match_s     = 1'b1;
                    tbl_wr_en_s = 1'b1;
                    state_next  = S_PR_SEND;
                end else if (last_probe_s) begin
                    state_next = S_RECEIVE;
                    if (found_r || !rd_valid_s) begin
                        store_s        = 1'b1;
                        tbl_wr_en_s    = 1'b1;
                        tbl_wr_valid_s = 1'b1;
                        tbl_wr_idx_s   = found_r ? empty_idx_r : slot_s;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    state_next = S_PROBE;
                end
            end
            S_PR_SEND: begin
                if (pr_done_s) begin
                    state_next = S_RECEIVE;
                end else begin
                    state_next = S_PR_SEND;
                end
            end
            default: begin
                state_next = S_RECEIVE;
            end
        endcase
    end

    // Handshake, request, occupancy, overflow and probe bookkeeping
    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_r    <= 1'b0;
            pr_valid_r <= 1'b0;
            pr_data_r  <= {PACKET_REQUEST_WIDTH{1'b0}};
            occ_r      <= {(IDX_WIDTH+1){1'b0}};
            ovf_r      <= 1'b0;
            probe_r    <= {IDX_WIDTH{1'b0}};
            found_r    <= 1'b0;
        end else begin
            ready_r <= (state_next == S_RECEIVE);
            if (accept_s) begin
                probe_r <= {IDX_WIDTH{1'b0}};
                found_r <= 1'b0;
            end else if (state_r == S_PROBE) begin
                probe_r <= probe_r + IDX_ONE;
                if (!found_r && !rd_valid_s) begin
                    found_r <= 1'b1;
                end
            end
            if (match_s) begin
                pr_valid_r <= 1'b1;
                pr_data_r  <= request_s;
                occ_r      <= occ_r - OCC_ONE;
            end else if (pr_done_s) begin
                pr_valid_r <= 1'b0;
            end
            if (store_s) begin
                occ_r <= occ_r + OCC_ONE;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Token latch and first-empty slot index; no reset needed
    always_ff @(posedge CLK) begin
        if (accept_s) begin
            tok_side_r  <= (wr_option_s == DEST_OPTION_RIGHT) ? SIDE_RIGHT : SIDE_LEFT;
            tok_addr_r  <= wr_addr_s;
            tok_color_r <= wr_color_s;
            tok_data_r  <= wr_data_s;
            hash_r      <= wr_addr_s[IDX_WIDTH-1:0] ^ wr_color_s[IDX_WIDTH-1:0];
        end
        if ((state_r == S_PROBE) && !found_r && !rd_valid_s) begin
            empty_idx_r <= slot_s;
        end
    end

    assign RECEIVE_WR_READY = ready_r;
    assign SEND_PR_VALID    = pr_valid_r;
    assign SEND_PR_DATA     = pr_data_r;
    assign OVERFLOW         = ovf_r;
    assign OCCUPANCY        = occ_r;

endmodule
